// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 keypad row scanner with column sync, debounce and single-pulse key output
module keypad_scanner #(
    parameter int SCAN_DIV = 4,
    parameter int DEBOUNCE = 3
) (
    input  logic       i_clk,
    input  logic       i_rst,
    output logic [3:0] o_row_n,
    input  logic [3:0] i_col_n,
    output logic [3:0] o_key,
    output logic       o_valid_key,
    output logic       o_key_held
);

    typedef enum logic [1:0] {S_SCAN, S_DEBOUNCE, S_HELD} state_t;

    localparam logic [7:0] DWELL_LAST = 8'(SCAN_DIV - 1);
    localparam logic [3:0] DB_COUNT   = 4'(DEBOUNCE);

    state_t     r_state, w_state_nxt;
    logic [3:0] r_sync1, r_sync2;
    logic [7:0] r_dwell;
    logic [1:0] r_row, w_row_nxt;
    logic [1:0] r_col, w_col_nxt;
    logic [3:0] r_cnt, w_cnt_nxt;
    logic [3:0] r_key, w_key_nxt;
    logic       r_valid, w_valid_nxt;
    logic       r_held, w_held_nxt;
    logic       w_sample, w_none, w_single;
    logic [1:0] w_col;
    logic [3:0] w_cnt_inc;

    assign w_sample  = (r_dwell == DWELL_LAST);
    assign w_none    = (r_sync2 == 4'b1111);
    assign w_cnt_inc = r_cnt + 4'd1;

    // Two or more low columns (ghosting) classify as neither none nor single.
    always_comb begin
        w_single = 1'b1;
        w_col    = 2'd0;
        case (r_sync2)
            4'b1110: w_col = 2'd0;
            4'b1101: w_col = 2'd1;
            4'b1011: w_col = 2'd2;
            4'b0111: w_col = 2'd3;
            default: w_single = 1'b0;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_row_nxt   = r_row;
        w_col_nxt   = r_col;
        w_cnt_nxt   = r_cnt;
        w_key_nxt   = r_key;
        w_valid_nxt = 1'b0;
        w_held_nxt  = r_held;
        if (w_sample) begin
            case (r_state)
                S_SCAN: begin
                    if (w_single) begin
                        w_col_nxt = w_col;
                        if (DEBOUNCE == 1) begin
                            w_key_nxt   = {r_row, w_col};
                            w_valid_nxt = 1'b1;
                            w_held_nxt  = 1'b1;
                            w_cnt_nxt   = 4'd0;
                            w_state_nxt = S_HELD;
                        end else begin
                            w_cnt_nxt   = 4'd1;
                            w_state_nxt = S_DEBOUNCE;
                        end
                    end else begin
                        w_row_nxt = r_row + 2'd1;
                    end
                end
                S_DEBOUNCE: begin
                    if (w_single && (w_col == r_col)) begin
                        if (w_cnt_inc == DB_COUNT) begin
                            w_key_nxt   = {r_row, r_col};
                            w_valid_nxt = 1'b1;
                            w_held_nxt  = 1'b1;
                            w_cnt_nxt   = 4'd0;
                            w_state_nxt = S_HELD;
                        end else begin
                            w_cnt_nxt = w_cnt_inc;
                        end
                    end else begin
                        w_cnt_nxt   = 4'd0;
                        w_row_nxt   = r_row + 2'd1;
                        w_state_nxt = S_SCAN;
                    end
                end
                S_HELD: begin
                    if (w_none) begin
                        if (w_cnt_inc == DB_COUNT) begin
                            w_held_nxt  = 1'b0;
                            w_cnt_nxt   = 4'd0;
                            w_row_nxt   = r_row + 2'd1;
                            w_state_nxt = S_SCAN;
                        end else begin
                            w_cnt_nxt = w_cnt_inc;
                        end
                    end else begin
                        w_cnt_nxt = 4'd0;
                    end
                end
                default: w_state_nxt = S_SCAN;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_SCAN;
            r_sync1 <= 4'b1111;
            r_sync2 <= 4'b1111;
            r_dwell <= 8'd0;
            r_row   <= 2'd0;
            r_col   <= 2'd0;
            r_cnt   <= 4'd0;
            r_key   <= 4'h0;
            r_valid <= 1'b0;
            r_held  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_sync1 <= i_col_n;
            r_sync2 <= r_sync1;
            r_dwell <= w_sample ? 8'd0 : r_dwell + 8'd1;
            r_row   <= w_row_nxt;
            r_col   <= w_col_nxt;
            r_cnt   <= w_cnt_nxt;
            r_key   <= w_key_nxt;
            r_valid <= w_valid_nxt;
            r_held  <= w_held_nxt;
        end
    end

    assign o_row_n     = ~(4'b0001 << r_row);
    assign o_key       = r_key;
    assign o_valid_key = r_valid;
    assign o_key_held  = r_held;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - scoreboard bench for keypad_scanner with a wired-AND keypad model
module tb_keypad_scanner;

    logic        clk;
    logic        rst;
    logic [3:0]  row_n;
    logic [3:0]  col_n;
    logic [3:0]  key;
    logic        valid_key;
    logic        key_held;
    logic [15:0] pressed;

    int          n_pass;
    int          n_total;
    logic [3:0]  exp_q[$];
    logic [3:0]  got_keys[0:63];
    int          wr_idx;
    int          rd_idx;
    int          consec_err;
    logic        prev_valid;

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE(3)) dut (
        .i_clk(clk),
        .i_rst(rst),
        .o_row_n(row_n),
        .i_col_n(col_n),
        .o_key(key),
        .o_valid_key(valid_key),
        .o_key_held(key_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        col_n = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !row_n[r]) col_n[c] = 1'b0;
    end

    initial begin
        wr_idx = 0;
        consec_err = 0;
        prev_valid = 1'b0;
    end

    always @(posedge clk) begin
        #1;
        if (valid_key) begin
            if (prev_valid) consec_err++;
            got_keys[wr_idx % 64] = key;
            wr_idx++;
        end
        prev_valid = valid_key;
    end

    task automatic set_key(input int r, input int c, input logic v);
        pressed[r*4+c] = v;
    endtask

    task automatic wait_release(input string name);
        int n;
        n = 0;
        while (key_held && n < 100) begin
            @(negedge clk);
            n++;
        end
        n_total++;
        if (key_held) $display("FAIL %s_release_timeout key_held=%b required 0", name, key_held);
        else n_pass++;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_total++; if (row_n !== 4'b1110) $display("FAIL reset_row_n got %b want 1110", row_n); else n_pass++;
        n_total++; if (key !== 4'h0) $display("FAIL reset_key got %h want 0", key); else n_pass++;
        n_total++; if (valid_key !== 1'b0) $display("FAIL reset_valid got %b want 0", valid_key); else n_pass++;
        n_total++; if (key_held !== 1'b0) $display("FAIL reset_held got %b want 0", key_held); else n_pass++;
        rst = 1'b0;
        for (int i = 0; i <= 16; i++) begin
            logic [3:0] exp_row;
            exp_row = ~(4'b0001 << ((i / 4) % 4));
            n_total++;
            if (row_n !== exp_row) $display("FAIL scan_step%0d row_n got %b want %b", i, row_n, exp_row);
            else n_pass++;
            @(negedge clk);
        end
    endtask

    task automatic test_latency;
        logic [3:0] e;
        rst = 1'b1;
        set_key(0, 0, 1'b1);
        repeat (2) @(negedge clk);
        exp_q.push_back(4'h0);
        rst = 1'b0;
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            if (i == 11) begin
                n_total++; if (valid_key !== 1'b0) $display("FAIL latency_early got %b want 0", valid_key); else n_pass++;
            end
            if (i == 12) begin
                n_total++; if (valid_key !== 1'b1) $display("FAIL latency_pulse got %b want 1", valid_key); else n_pass++;
            end
            if (i == 13) begin
                n_total++; if (valid_key !== 1'b0) $display("FAIL latency_width got %b want 0", valid_key); else n_pass++;
            end
        end
        n_total++;
        if (wr_idx == rd_idx) $display("FAIL latency_record no pulse seen want key 0");
        else begin
            e = exp_q.pop_front();
            if (got_keys[rd_idx % 64] !== e) $display("FAIL latency_key got %h want %h", got_keys[rd_idx % 64], e);
            else n_pass++;
            rd_idx++;
        end
        set_key(0, 0, 1'b0);
        wait_release("latency");
    endtask

    task automatic test_press_b;
        int cyc;
        int n;
        logic [3:0] e;
        exp_q.push_back(4'hB);
        set_key(2, 3, 1'b1);
        cyc = 0;
        while (wr_idx == rd_idx && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        n_total++;
        if (wr_idx == rd_idx) $display("FAIL press_b_timeout no pulse want key b");
        else begin
            e = exp_q.pop_front();
            if (got_keys[rd_idx % 64] !== e) $display("FAIL press_b_key got %h want %h", got_keys[rd_idx % 64], e);
            else n_pass++;
            rd_idx++;
        end
        n_total++; if (key_held !== 1'b1) $display("FAIL press_b_held_at_pulse got %b want 1", key_held); else n_pass++;
        while (cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        n_total++; if (key_held !== 1'b1) $display("FAIL press_b_held_60 got %b want 1", key_held); else n_pass++;
        n_total++; if (wr_idx != rd_idx) $display("FAIL press_b_single_pulse extra pulses %0d want 0", wr_idx - rd_idx); else n_pass++;
        set_key(2, 3, 1'b0);
        n = 0;
        while (key_held && n < 40) begin
            @(negedge clk);
            n++;
        end
        n_total++;
        if (n < 11 || n > 14) $display("FAIL press_b_release_cycles got %0d want 11..14", n); else n_pass++;
        n_total++; if (row_n !== 4'b0111) $display("FAIL press_b_resume_row got %b want 0111", row_n); else n_pass++;
        n_total++; if (key !== 4'hB) $display("FAIL press_b_key_hold got %h want b", key); else n_pass++;
    endtask

    task automatic test_bounce;
        set_key(1, 0, 1'b1);
        repeat (5) @(negedge clk);
        set_key(1, 0, 1'b0);
        repeat (40) @(negedge clk);
        n_total++; if (wr_idx != rd_idx) $display("FAIL bounce_pulse got %0d pulses want 0", wr_idx - rd_idx); else n_pass++;
        n_total++; if (key !== 4'hB) $display("FAIL bounce_key got %h want b", key); else n_pass++;
        n_total++; if (key_held !== 1'b0) $display("FAIL bounce_held got %b want 0", key_held); else n_pass++;
    endtask

    task automatic test_ghost;
        int cyc;
        logic [3:0] e;
        set_key(0, 1, 1'b1);
        set_key(0, 2, 1'b1);
        repeat (40) @(negedge clk);
        n_total++; if (wr_idx != rd_idx) $display("FAIL ghost_pulse got %0d pulses want 0", wr_idx - rd_idx); else n_pass++;
        n_total++; if (key_held !== 1'b0) $display("FAIL ghost_held got %b want 0", key_held); else n_pass++;
        exp_q.push_back(4'h1);
        set_key(0, 2, 1'b0);
        cyc = 0;
        while (wr_idx == rd_idx && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        n_total++;
        if (wr_idx == rd_idx) $display("FAIL ghost_timeout no pulse want key 1");
        else begin
            e = exp_q.pop_front();
            if (got_keys[rd_idx % 64] !== e) $display("FAIL ghost_key got %h want %h", got_keys[rd_idx % 64], e);
            else n_pass++;
            rd_idx++;
        end
        set_key(0, 1, 1'b0);
        wait_release("ghost");
    endtask

    task automatic test_reset_mid;
        int cyc;
        logic [3:0] e;
        cyc = 0;
        while (row_n !== 4'b1110 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        set_key(3, 3, 1'b1);
        cyc = 0;
        while (row_n !== 4'b0111 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        n_total++; if (row_n !== 4'b0111) $display("FAIL rstmid_reach_row3 got %b want 0111", row_n); else n_pass++;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        #1;
        n_total++; if (row_n !== 4'b1110) $display("FAIL rstmid_row_n got %b want 1110", row_n); else n_pass++;
        n_total++; if (key !== 4'h0) $display("FAIL rstmid_key got %h want 0", key); else n_pass++;
        n_total++; if (key_held !== 1'b0) $display("FAIL rstmid_held got %b want 0", key_held); else n_pass++;
        repeat (2) @(negedge clk);
        n_total++; if (wr_idx != rd_idx) $display("FAIL rstmid_no_pulse got %0d pulses want 0", wr_idx - rd_idx); else n_pass++;
        exp_q.push_back(4'hF);
        rst = 1'b0;
        cyc = 0;
        while (wr_idx == rd_idx && cyc < 80) begin
            @(negedge clk);
            cyc++;
        end
        n_total++;
        if (wr_idx == rd_idx) $display("FAIL rstmid_timeout no pulse want key f");
        else begin
            e = exp_q.pop_front();
            if (got_keys[rd_idx % 64] !== e) $display("FAIL rstmid_key_after got %h want %h", got_keys[rd_idx % 64], e);
            else n_pass++;
            rd_idx++;
        end
        set_key(3, 3, 1'b0);
        wait_release("rstmid");
    endtask

    task automatic test_back_to_back;
        int seq_r[6] = '{2, 0, 0, 1, 1, 3};
        int seq_c[6] = '{3, 2, 3, 0, 1, 0};
        logic [3:0] seq_k[6] = '{4'hB, 4'h2, 4'h3, 4'h4, 4'h5, 4'hC};
        int start;
        int cyc;
        logic [3:0] e;
        start = wr_idx;
        for (int k = 0; k < 6; k++) begin
            exp_q.push_back(seq_k[k]);
            set_key(seq_r[k], seq_c[k], 1'b1);
            cyc = 0;
            while (wr_idx == start + k && cyc < 80) begin
                @(negedge clk);
                cyc++;
            end
            set_key(seq_r[k], seq_c[k], 1'b0);
            wait_release("seq");
        end
        n_total++; if (wr_idx - start != 6) $display("FAIL seq_count got %0d pulses want 6", wr_idx - start); else n_pass++;
        while (rd_idx < wr_idx && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_total++;
            if (got_keys[rd_idx % 64] !== e) $display("FAIL seq_key%0d got %h want %h", rd_idx - start, got_keys[rd_idx % 64], e);
            else n_pass++;
            rd_idx++;
        end
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        rd_idx = 0;
        pressed = 16'h0;
        rst = 1'b1;
        test_reset;
        test_latency;
        test_press_b;
        test_bounce;
        test_ghost;
        test_reset_mid;
        test_back_to_back;
        n_total++; if (consec_err != 0) $display("FAIL consecutive_valid got %0d want 0", consec_err); else n_pass++;
        n_total++; if (exp_q.size() != 0) $display("FAIL scoreboard_leftover got %0d want 0", exp_q.size()); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
